// File: rtl/erg_pkg.sv
// rtl/erg_pkg.sv - shared phase encoding and parameter defaults for the erg stroke detector
package erg_pkg;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_DRIVE    = 2'd1,
    PH_RECOVERY = 2'd2
  } phase_e;

  localparam int CNT_W_DEF    = 20;
  localparam int DEBOUNCE_DEF = 4;
  localparam int HYST_DEF     = 2;
  localparam int CONFIRM_DEF  = 2;
  localparam int PULSE_W_DEF  = 8;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - 2-flop synchroniser, run-length debouncer and rising-edge tick
module sensor_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sensor_in,
  output logic tick
);

  localparam int RW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          tick_q, tick_d;
  logic [RW-1:0] run_q, run_d;

  // run_q counts consecutive samples that disagree with the accepted level
  always_comb begin
    level_d = level_q;
    tick_d  = 1'b0;
    run_d   = '0;
    if (sync2_q != level_q) begin
      if (run_q == RW'(DEBOUNCE - 1)) begin
        level_d = sync2_q;
        tick_d  = sync2_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      tick_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= sensor_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      tick_q  <= tick_d;
      run_q   <= run_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/stroke_phase_detector.sv
// rtl/stroke_phase_detector.sv - flywheel period measurement, accel/decel voting and drive/recovery phase FSM
module stroke_phase_detector
  import erg_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int HYST     = HYST_DEF,
  parameter int CONFIRM  = CONFIRM_DEF,
  parameter int PULSE_W  = PULSE_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sensor_in,
  output logic             start_drive,
  output logic             start_recovery,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
);

  localparam int VW = $clog2(CONFIRM + 1);
  localparam int PW = $clog2(PULSE_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   HYST_EXT = (CNT_W + 1)'(HYST);

  logic             tick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic [CNT_W-1:0] pp_q, pp_d;
  logic             pp_valid_q, pp_valid_d;
  logic [VW-1:0]    vote_cnt_q, vote_cnt_d;
  logic             vote_accel_q, vote_accel_d;
  phase_e           phase_q, phase_d;
  logic             fire_drive_q, fire_drive_d;
  logic             fire_rec_q, fire_rec_d;
  logic [PW-1:0]    pulse_cnt_q, pulse_cnt_d;
  logic             pulse_rec_q, pulse_rec_d;

  logic             sat, accel, decel;
  logic [VW-1:0]    vote_next;
  logic [CNT_W:0]   p_ext, pp_ext;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clock    (clock),
    .reset_n  (reset_n),
    .sensor_in(sensor_in),
    .tick     (tick)
  );

  assign sat    = (cnt_q == CNT_MAX);
  assign p_ext  = {1'b0, cnt_q};
  assign pp_ext = {1'b0, pp_q};
  assign accel  = (p_ext + HYST_EXT) < pp_ext;
  assign decel  = p_ext > (pp_ext + HYST_EXT);

  always_comb begin
    cnt_d        = tick ? '0 : (sat ? cnt_q : cnt_q + 1'b1);
    period_d     = period_q;
    pv_d         = 1'b0;
    pp_d         = pp_q;
    pp_valid_d   = pp_valid_q;
    vote_cnt_d   = vote_cnt_q;
    vote_accel_d = vote_accel_q;
    phase_d      = phase_q;
    fire_drive_d = 1'b0;
    fire_rec_d   = 1'b0;
    vote_next    = '0;

    // Saturation wins over a coincident tick: the stroke is considered lost
    if (sat) begin
      phase_d    = PH_IDLE;
      pp_valid_d = 1'b0;
      vote_cnt_d = '0;
    end else if (tick) begin
      period_d   = cnt_q;
      pv_d       = 1'b1;
      pp_d       = cnt_q;
      pp_valid_d = 1'b1;
      if (pp_valid_q) begin
        if (!accel && !decel) begin
          vote_cnt_d = '0;
        end else begin
          if (vote_cnt_q != '0 && vote_accel_q == accel)
            vote_next = (vote_cnt_q == VW'(CONFIRM)) ? vote_cnt_q : vote_cnt_q + 1'b1;
          else
            vote_next = VW'(1);
          vote_accel_d = accel;
          vote_cnt_d   = vote_next;
          if (vote_next == VW'(CONFIRM)) begin
            case (phase_q)
              PH_IDLE, PH_RECOVERY: if (accel) begin
                phase_d      = PH_DRIVE;
                fire_drive_d = 1'b1;
                vote_cnt_d   = '0;
              end
              PH_DRIVE: if (decel) begin
                phase_d    = PH_RECOVERY;
                fire_rec_d = 1'b1;
                vote_cnt_d = '0;
              end
              default: phase_d = PH_IDLE;
            endcase
          end
        end
      end
    end
  end

  // A fresh transition reloads the pulse timer, cutting any pulse in flight
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    pulse_rec_d = pulse_rec_q;
    if (fire_drive_q || fire_rec_q) begin
      pulse_cnt_d = PW'(PULSE_W);
      pulse_rec_d = fire_rec_q;
    end else if (pulse_cnt_q != '0) begin
      pulse_cnt_d = pulse_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      period_q     <= '0;
      pv_q         <= 1'b0;
      pp_q         <= '0;
      pp_valid_q   <= 1'b0;
      vote_cnt_q   <= '0;
      vote_accel_q <= 1'b0;
      phase_q      <= PH_IDLE;
      fire_drive_q <= 1'b0;
      fire_rec_q   <= 1'b0;
      pulse_cnt_q  <= '0;
      pulse_rec_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      pv_q         <= pv_d;
      pp_q         <= pp_d;
      pp_valid_q   <= pp_valid_d;
      vote_cnt_q   <= vote_cnt_d;
      vote_accel_q <= vote_accel_d;
      phase_q      <= phase_d;
      fire_drive_q <= fire_drive_d;
      fire_rec_q   <= fire_rec_d;
      pulse_cnt_q  <= pulse_cnt_d;
      pulse_rec_q  <= pulse_rec_d;
    end
  end

  assign start_drive    = (pulse_cnt_q != '0) && !pulse_rec_q;
  assign start_recovery = (pulse_cnt_q != '0) &&  pulse_rec_q;
  assign phase          = phase_q;
  assign period         = period_q;
  assign period_valid   = pv_q;

endmodule
